sq_iter_ctrl: RTL and testbench
===============================

// Module: sq_iter_ctrl
// PURPOSE
//  Sequencer for the repeated-modular-squaring loop. Drives enables for the
//  square stage, the reduction/lookup stage and the 130-digit carry-save
//  accumulate stage, then feeds the accumulated C/S value back as the next
//  squaring input. Counts T iterations and then signals completion.
//  Sits between the host/top-level control and the squarer/accumulator datapath.
// PARAMETERS
//  ITER_W   64  width of the iteration count and of the progress counters
//  SQ_LAT   2   cycles sq_en is held per iteration (square stage depth); >=1
//  RED_LAT  2   cycles red_en is held per iteration (reduction stage depth); >=1
// PORTS
//  clk         in   1       single clock; all state changes on the rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       request to run; sampled only in IDLE or DONE
//  abort       in   1       cancel a run in progress; highest priority after reset
//  iter_count  in   ITER_W  number of squarings T; captured when start is accepted
//  load_en     out  1       load the external operand into the loop register
//  sq_en       out  1       advance the square stage
//  red_en      out  1       advance the reduction/lookup stage
//  acc_en      out  1       capture the accumulator C/S outputs into the loop register
//  busy        out  1       high from LOAD through the last ACC cycle
//  done        out  1       one-cycle pulse after the final ACC
//  iters_left  out  ITER_W  iterations still to complete, including the one in flight
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE. All outputs are 0, including iters_left.
//  States: IDLE, LOAD, SQ, RED, ACC, DONE. A phase counter ph counts cycles inside SQ and RED.
//  IDLE: when start=1, capture T=iter_count and go to LOAD. Otherwise stay.
//  LOAD: one cycle; load_en=1 and iters_left=T. Go to DONE if T==0, otherwise go to SQ with ph=0.
//  SQ:   sq_en=1 for SQ_LAT cycles. When ph==SQ_LAT-1, go to RED with ph=0.
//  RED:  red_en=1 for RED_LAT cycles. When ph==RED_LAT-1, go to ACC.
//  ACC:  one cycle; acc_en=1 and iters_left decrements at the end of the cycle.
//        If iters_left==1 before the decrement, go to DONE; otherwise go to SQ with ph=0.
//  DONE: one cycle; done=1 and busy=0, iters_left=0.
//        start=1 here is accepted like IDLE (back-to-back runs); otherwise go to IDLE.
//  Enable signals are mutually exclusive; at most one of load_en/sq_en/red_en/acc_en is high.
//  The outputs are decoded registered state, so there are no combinational paths from inputs to outputs.
//  Latency: with L = SQ_LAT+RED_LAT+1 and start sampled at edge k,
//           LOAD is cycle k+1 and done is cycle k+2+T*L (T=0: done at k+2).
//  start while busy: ignored. The captured T is unchanged, and a later iter_count change is ignored.
//  abort=1 in any state: next state is IDLE. No done pulse, enables drop the next cycle,
//           iters_left=0. The loop register contents are undefined to the host.
//  abort and start together in IDLE/DONE: abort wins and the state stays/returns IDLE.
//  T = all-ones: iters_left counts down without wrap. No counter saturates or overflows,
//           because the only arithmetic is a decrement guarded by iters_left!=0.
//  rst_n asserted mid-run: immediately IDLE, all outputs 0. On release, wait for a new start.
// TESTING
//  1 Defaults, start at edge 0, T=3: load_en@1; sq_en@2-3,7-8,12-13; red_en@4-5,9-10,14-15;
//    acc_en@6,11,16; done@17; busy high for 1..16; iters_left 3,2,1,0 after each acc_en.
//  2 T=0: load_en@1, done@2, no sq_en/red_en/acc_en ever asserted, iters_left=0 at done.
//  3 T=2 run, start held high through DONE with iter_count=1: second LOAD in the cycle after done,
//    second done at LOAD+1+5; start pulses during busy do not alter iters_left.
//  4 T=4, abort asserted during 2nd RED: next cycle IDLE, all enables 0, done never pulses;
//    a following start with T=1 completes normally (done 7 cycles after start edge).
//  5 T=5, rst_n pulled low asynchronously mid-SQ: outputs 0 before next clk edge;
//    after release, no activity until start.
//  6 SQ_LAT=1, RED_LAT=3, T=2: per-iteration pattern sq,red,red,red,acc (L=5), done@12;
//    check enable one-hot every cycle.

Source files
------------

// File: rtl/sq_iter_if.sv
// Host <-> squaring-loop sequencer handshake bundle.
// Host drives start/abort/count; sequencer drives stage enables and status.
interface sq_iter_if #(
  parameter int ITER_W = 64
);
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] iter_count;
  logic              load_en;
  logic              sq_en;
  logic              red_en;
  logic              acc_en;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iters_left;

  modport master (
    output start, abort, iter_count,
    input  load_en, sq_en, red_en, acc_en,
    input  busy, done, iters_left
  );

  modport slave (
    input  start, abort, iter_count,
    output load_en, sq_en, red_en, acc_en,
    output busy, done, iters_left
  );
endinterface

// File: rtl/sq_iter_ctrl.sv
// Repeated-modular-squaring sequencer: load, then T x (square, reduce,
// accumulate), then a one-cycle done pulse. All outputs are registered.
module sq_iter_ctrl #(
  parameter int ITER_W  = 64,
  parameter int SQ_LAT  = 2,
  parameter int RED_LAT = 2
) (
  input logic     clk,
  input logic     rst_n,
  sq_iter_if.slave bus
);

  localparam int MAXL = (SQ_LAT > RED_LAT) ? SQ_LAT : RED_LAT;
  localparam int PH_W = $clog2(MAXL + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SQ, RED, ACC, DONE
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ph;
  logic              load_en;
  logic              sq_en;
  logic              red_en;
  logic              acc_en;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iters_left;

  // Outputs are set together with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ph         <= '0;
      load_en    <= 1'b0;
      sq_en      <= 1'b0;
      red_en     <= 1'b0;
      acc_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iters_left <= '0;
    end else begin
      load_en <= 1'b0;
      sq_en   <= 1'b0;
      red_en  <= 1'b0;
      acc_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      if (bus.abort) begin
        state      <= IDLE;
        ph         <= '0;
        iters_left <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              state      <= LOAD;
              load_en    <= 1'b1;
              busy       <= 1'b1;
              iters_left <= bus.iter_count;
            end else begin
              state      <= IDLE;
              iters_left <= '0;
            end
          end
          LOAD: begin
            ph <= '0;
            if (iters_left == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SQ;
              sq_en <= 1'b1;
              busy  <= 1'b1;
            end
          end
          SQ: begin
            busy <= 1'b1;
            if (ph == PH_W'(SQ_LAT - 1)) begin
              state  <= RED;
              ph     <= '0;
              red_en <= 1'b1;
            end else begin
              ph    <= ph + PH_W'(1);
              sq_en <= 1'b1;
            end
          end
          RED: begin
            busy <= 1'b1;
            if (ph == PH_W'(RED_LAT - 1)) begin
              state  <= ACC;
              ph     <= '0;
              acc_en <= 1'b1;
            end else begin
              ph     <= ph + PH_W'(1);
              red_en <= 1'b1;
            end
          end
          ACC: begin
            if (iters_left != '0)
              iters_left <= iters_left - ITER_W'(1);
            ph <= '0;
            if (iters_left == ITER_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SQ;
              sq_en <= 1'b1;
              busy  <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            iters_left <= '0;
          end
        endcase
      end
    end
  end

  assign bus.load_en    = load_en;
  assign bus.sq_en      = sq_en;
  assign bus.red_en     = red_en;
  assign bus.acc_en     = acc_en;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.iters_left = iters_left;

endmodule

// File: tb/tb_sq_iter_ctrl.sv
// Bench for sq_iter_ctrl: schedule-arithmetic model checked every cycle
// plus directed literal checks on two parameterisations.
module tb_sq_iter_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sq_iter_if #(.ITER_W(64)) ia ();
  sq_iter_if #(.ITER_W(64)) ib ();

  sq_iter_ctrl #(.ITER_W(64), .SQ_LAT(2), .RED_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );
  sq_iter_ctrl #(.ITER_W(64), .SQ_LAT(1), .RED_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  typedef struct packed {
    logic        load;
    logic        sq;
    logic        red;
    logic        acc;
    logic        busy;
    logic        done;
    logic [63:0] left;
  } exp_t;

  int tests = 0;
  int fails = 0;
  longint unsigned ecount = 0;

  bit              act_a = 0, act_b = 0;
  longint unsigned s_a = 0, s_b = 0;
  logic [63:0]     t_a = '0, t_b = '0;

  // Expected outputs of interval n for a run whose LOAD is interval s.
  function automatic exp_t model(int sql, int redl, bit act,
                                 longint unsigned s, logic [63:0] t,
                                 longint unsigned n);
    exp_t r;
    longint unsigned off, q, j, l;
    r = '0;
    l = longint'(sql + redl + 1);
    if (!act || n < s) return r;
    off = n - s;
    if (off == 0) begin
      r.load = 1; r.busy = 1; r.left = t;
      return r;
    end
    q = (off - 1) / l;
    j = (off - 1) % l;
    if (q < t) begin
      r.busy = 1;
      r.left = t - q;
      if (j < longint'(sql)) r.sq = 1;
      else if (j < longint'(sql + redl)) r.red = 1;
      else r.acc = 1;
    end else if (q == t && j == 0) begin
      r.done = 1;
    end
    return r;
  endfunction

  always @(negedge rst_n) begin
    act_a = 0;
    act_b = 0;
  end

  always @(posedge clk) begin
    exp_t ca, cb;
    if (rst_n) begin
      ca = model(2, 2, act_a, s_a, t_a, ecount);
      cb = model(1, 3, act_b, s_b, t_b, ecount);
      if (ia.abort) act_a = 0;
      else if (!ca.busy && ia.start) begin
        act_a = 1; s_a = ecount + 1; t_a = ia.iter_count;
      end
      if (ib.abort) act_b = 0;
      else if (!cb.busy && ib.start) begin
        act_b = 1; s_b = ecount + 1; t_b = ib.iter_count;
      end
    end
    ecount = ecount + 1;
  end

  always @(negedge clk) begin
    exp_t ea, eb, ga, gb;
    if (rst_n) begin
      ea = model(2, 2, act_a, s_a, t_a, ecount);
      eb = model(1, 3, act_b, s_b, t_b, ecount);
      ga = {ia.load_en, ia.sq_en, ia.red_en, ia.acc_en,
            ia.busy, ia.done, ia.iters_left};
      gb = {ib.load_en, ib.sq_en, ib.red_en, ib.acc_en,
            ib.busy, ib.done, ib.iters_left};
      tests++;
      if (ga !== ea) begin
        fails++;
        $display("FAIL cyc_a n=%0d got=%h exp=%h", ecount, ga, ea);
      end
      tests++;
      if (gb !== eb) begin
        fails++;
        $display("FAIL cyc_b n=%0d got=%h exp=%h", ecount, gb, eb);
      end
      tests++;
      if ($countones({ib.load_en, ib.sq_en, ib.red_en, ib.acc_en}) > 1 ||
          $countones({ia.load_en, ia.sq_en, ia.red_en, ia.acc_en}) > 1) begin
        fails++;
        $display("FAIL onehot n=%0d got_a=%b got_b=%b exp=<=1 hot", ecount,
                 {ia.load_en, ia.sq_en, ia.red_en, ia.acc_en},
                 {ib.load_en, ib.sq_en, ib.red_en, ib.acc_en});
      end
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_a(logic [63:0] t);
    ia.start = 1; ia.iter_count = t;
    tick(1);
    ia.start = 0;
  endtask

  initial begin
    ia.start = 0; ia.abort = 0; ia.iter_count = '0;
    ib.start = 0; ib.abort = 0; ib.iter_count = '0;
    tick(1);
    chk("rst_busy", {63'd0, ia.busy}, 64'd0);
    chk("rst_left", ia.iters_left, 64'd0);
    chk("rst_b_en", {60'd0, ib.load_en, ib.sq_en, ib.red_en, ib.acc_en}, 64'd0);
    rst_n = 1;
    tick(2);

    // T=3 default run
    go_a(64'd3);
    chk("t1_load", {63'd0, ia.load_en}, 64'd1);
    chk("t1_left0", ia.iters_left, 64'd3);
    tick(5);
    chk("t1_acc", {63'd0, ia.acc_en}, 64'd1);
    chk("t1_accleft", ia.iters_left, 64'd3);
    tick(1);
    chk("t1_sq2", {63'd0, ia.sq_en}, 64'd1);
    chk("t1_left1", ia.iters_left, 64'd2);
    tick(10);
    chk("t1_done", {63'd0, ia.done}, 64'd1);
    chk("t1_dbusy", {63'd0, ia.busy}, 64'd0);
    chk("t1_dleft", ia.iters_left, 64'd0);
    tick(2);

    // T=0
    go_a(64'd0);
    chk("t2_load", {63'd0, ia.load_en}, 64'd1);
    tick(1);
    chk("t2_done", {63'd0, ia.done}, 64'd1);
    tick(2);

    // back-to-back, start held high through busy with a new count
    ia.start = 1; ia.iter_count = 64'd2;
    tick(1);
    ia.iter_count = 64'd1;
    tick(5);
    chk("t3_left", ia.iters_left, 64'd2);
    tick(6);
    chk("t3_done1", {63'd0, ia.done}, 64'd1);
    tick(1);
    chk("t3_load2", {63'd0, ia.load_en}, 64'd1);
    chk("t3_left2", ia.iters_left, 64'd1);
    ia.start = 0;
    tick(6);
    chk("t3_done2", {63'd0, ia.done}, 64'd1);
    tick(2);

    // abort during second RED
    go_a(64'd4);
    tick(8);
    chk("t4_red2", {63'd0, ia.red_en}, 64'd1);
    ia.abort = 1;
    tick(1);
    ia.abort = 0;
    chk("t4_busy", {63'd0, ia.busy}, 64'd0);
    chk("t4_left", ia.iters_left, 64'd0);
    tick(3);
    go_a(64'd1);
    tick(6);
    chk("t4_done", {63'd0, ia.done}, 64'd1);
    tick(2);

    // abort beats start in IDLE
    ia.start = 1; ia.abort = 1; ia.iter_count = 64'd3;
    tick(1);
    ia.start = 0; ia.abort = 0;
    chk("ab_st_load", {63'd0, ia.load_en}, 64'd0);
    tick(1);

    // all-ones count decrements without wrap, then abort
    go_a('1);
    chk("max_left", ia.iters_left, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(6);
    chk("max_left1", ia.iters_left, 64'hFFFF_FFFF_FFFF_FFFE);
    ia.abort = 1;
    tick(1);
    ia.abort = 0;
    tick(1);

    // async reset mid-SQ
    go_a(64'd5);
    tick(1);
    chk("t5_sq", {63'd0, ia.sq_en}, 64'd1);
    #1 rst_n = 0;
    #1;
    chk("t5_rsq", {63'd0, ia.sq_en}, 64'd0);
    chk("t5_rbusy", {63'd0, ia.busy}, 64'd0);
    chk("t5_rleft", ia.iters_left, 64'd0);
    tick(2);
    rst_n = 1;
    tick(4);
    chk("t5_idle", {62'd0, ia.busy, ia.load_en}, 64'd0);

    // SQ_LAT=1, RED_LAT=3, T=2
    ib.start = 1; ib.iter_count = 64'd2;
    tick(1);
    ib.start = 0;
    chk("t6_load", {63'd0, ib.load_en}, 64'd1);
    tick(2);
    chk("t6_red", {63'd0, ib.red_en}, 64'd1);
    tick(3);
    chk("t6_acc", {63'd0, ib.acc_en}, 64'd1);
    tick(6);
    chk("t6_done", {63'd0, ib.done}, 64'd1);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
